// File: rtl/instr_fetch.sv
// instr_fetch: program-RAM fetch stage with a 2-entry prefetch queue and redirect flush.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_addr, mem_ren          program RAM read address / read request
//   mem_rdata                  RAM read data, valid the cycle after mem_ren
//   instr, instr_pc            head-of-queue word and its full 32-bit PC
//   instr_valid, instr_ready   handshake towards execute
//   redirect, redirect_pc      one-cycle flush pulse and new fetch PC
module instr_fetch #(
  parameter logic [31:0] START_PC = 32'd0,
  parameter int ADDR_WIDTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic mem_ren,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic instr_valid,
  input  logic instr_ready,
  input  logic redirect,
  input  logic [31:0] redirect_pc
);
  logic [31:0] fetch_pc, inflight_pc;
  logic inflight, pop, push;
  logic [31:0] word_q [2];
  logic [31:0] pc_q [2];
  logic [1:0] count, left;
  assign instr = word_q[0];
  assign instr_pc = pc_q[0];
  assign instr_valid = count != 2'd0;
  assign mem_addr = fetch_pc[ADDR_WIDTH-1:0];
  // Entries remaining after this cycle's pop; a pushed word lands in the slot just past them.
  always_comb begin
    pop = instr_valid & instr_ready;
    push = inflight & ~redirect;
    left = count - {1'b0, pop};
    // Credit: queued plus in-flight words never exceed the two queue slots.
    mem_ren = ~redirect & (((count + {1'b0, inflight}) < 2'd2) | pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
      inflight <= 1'b0;
      inflight_pc <= 32'd0;
      count <= 2'd0;
      word_q[0] <= 32'd0;
      word_q[1] <= 32'd0;
      pc_q[0] <= 32'd0;
      pc_q[1] <= 32'd0;
    end else begin
      // mem_ren is already low during redirect, so the flushed read never returns.
      inflight <= mem_ren;
      if (mem_ren) inflight_pc <= fetch_pc;
      fetch_pc <= redirect ? redirect_pc : fetch_pc + {31'd0, mem_ren};
      count <= redirect ? 2'd0 : left + {1'b0, push};
      word_q[0] <= (push && left == 2'd0) ? mem_rdata : pop ? word_q[1] : word_q[0];
      pc_q[0] <= (push && left == 2'd0) ? inflight_pc : pop ? pc_q[1] : pc_q[0];
      if (push && left == 2'd1) begin
        word_q[1] <= mem_rdata;
        pc_q[1] <= inflight_pc;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch against a credit/latency model.
module tb_instr_fetch;
  localparam int AW = 11;
  localparam logic [31:0] SPC = 32'd0;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic mem_ren, instr_valid, instr_ready = 1'b0, redirect = 1'b0;
  logic [31:0] mem_rdata = 32'd0, instr, instr_pc, redirect_pc = 32'd0;
  instr_fetch #(.START_PC(SPC), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc));
  always #5 clk = ~clk;
  logic [31:0] ram [2**AW];
  always @(posedge clk) if (mem_ren) mem_rdata <= ram[mem_addr];
  // Model: every issued read is an outstanding credit until popped; it becomes visible 2 cycles after issue.
  typedef struct { logic [31:0] pc; int avail; } ent_t;
  ent_t q[$];
  logic [31:0] mpc;
  int cyc = 0, vectors = 0, errs = 0;
  logic exp_valid, exp_ren, m_pop;
  logic [31:0] exp_instr, exp_pc;
  logic [AW-1:0] exp_addr;
  function automatic string got_s();
    return $sformatf("valid=%b ren=%b addr=%0d instr=%h pc=%0d", instr_valid, mem_ren, mem_addr, instr, instr_pc);
  endfunction
  function automatic string want_s();
    return $sformatf("valid=%b ren=%b addr=%0d instr=%h pc=%0d", exp_valid, exp_ren, exp_addr, exp_instr, exp_pc);
  endfunction
  task automatic model_reset();
    q.delete();
    mpc = SPC;
  endtask
  task automatic drive(input logic r, input logic red, input logic [31:0] rpc);
    instr_ready = r;
    redirect = red;
    redirect_pc = rpc;
    #1;
    exp_valid = q.size() > 0 && q[0].avail <= cyc;
    exp_pc = exp_valid ? q[0].pc : 32'd0;
    exp_instr = exp_valid ? ram[exp_pc[AW-1:0]] : 32'd0;
    m_pop = exp_valid & r;
    exp_ren = !red && (q.size() - int'(m_pop)) < 2;
    exp_addr = mpc[AW-1:0];
  endtask
  task automatic tick();
    @(posedge clk);
    if (redirect) begin
      q.delete();
      mpc = redirect_pc;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (exp_ren) begin
        q.push_back('{pc: mpc, avail: cyc + 2});
        mpc = mpc + 32'd1;
      end
    end
    if (q.size() > 2) begin
      errs++;
      $display("FAIL overflow: queue holds %0d words, limit 2", q.size());
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 || mem_addr !== SPC[AW-1:0]) begin
      errs++;
      $display("FAIL reset: got %s want valid=0 instr=0 pc=0 addr=%0d", got_s(), SPC[AW-1:0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    vectors++;
    if (mem_ren !== 1'b1 || mem_addr !== SPC[AW-1:0]) begin
      errs++;
      $display("FAIL reset_release: got %s want ren=1 addr=%0d", got_s(), SPC[AW-1:0]);
    end
  endtask
  task automatic test_startup();
    int first = -1;
    ram[0] = 32'h20000001; ram[1] = 32'h10000010; ram[2] = 32'h20000000; ram[3] = 32'h30000000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL startup c%0d: got %s want %s", i, got_s(), want_s());
      end
      if (first < 0 && instr_valid === 1'b1) first = i;
      tick();
    end
    vectors++;
    if (first !== 2) begin
      errs++;
      $display("FAIL startup_latency: first valid cycle %0d want 2", first);
    end
  endtask
  task automatic test_stall();
    int issues = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(i >= 12, 1'b0, 32'd0);
      if (i < 12 && mem_ren === 1'b1) issues++;
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL stall c%0d: got %s want %s", i, got_s(), want_s());
      end
      tick();
    end
    vectors++;
    if (issues !== 2) begin
      errs++;
      $display("FAIL stall_issues: got %0d reads want 2", issues);
    end
  endtask
  task automatic test_redirect();
    int valid_at = -1;
    do_reset();
    ram[32'h40] = 32'hCAFE0040;
    for (int i = 0; i < 12; i++) begin
      drive(i > 5, i == 5, 32'h40);
      if (i > 5 && valid_at < 0 && instr_valid === 1'b1) valid_at = i;
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL redirect c%0d: got %s want %s", i, got_s(), want_s());
      end
      if (i == 8) begin
        vectors++;
        if (instr_pc !== 32'h40 || instr !== 32'hCAFE0040) begin
          errs++;
          $display("FAIL redirect_target: got instr=%h pc=%h want CAFE0040 pc=40", instr, instr_pc);
        end
      end
      tick();
    end
    vectors++;
    if (valid_at !== 8) begin
      errs++;
      $display("FAIL redirect_latency: first valid at c%0d want c8", valid_at);
    end
  endtask
  task automatic test_redirect_pop();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i == 4, 32'd300);
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL redirect_pop c%0d: got %s want %s", i, got_s(), want_s());
      end
      tick();
    end
  endtask
  task automatic test_wrap();
    drive(1'b1, 1'b1, 32'd2046);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL wrap c%0d: got %s want %s", i, got_s(), want_s());
      end
      if (i == 4) begin
        vectors++;
        if (instr_pc !== 32'd2048) begin
          errs++;
          $display("FAIL wrap_pc: got %0d want 2048", instr_pc);
        end
      end
      tick();
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i < 3, 32'd100 + 32'(i * 10));
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL back_to_back c%0d: got %s want %s", i, got_s(), want_s());
      end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_addr !== SPC[AW-1:0]) begin
      errs++;
      $display("FAIL reset_mid: got %s want valid=0 addr=%0d", got_s(), SPC[AW-1:0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL reset_mid c%0d: got %s want %s", i, got_s(), want_s());
      end
      tick();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 4095)));
      vectors++;
      if (instr_valid !== exp_valid || mem_ren !== exp_ren || mem_addr !== exp_addr ||
          (exp_valid && (instr !== exp_instr || instr_pc !== exp_pc))) begin
        errs++;
        $display("FAIL random c%0d: got %s want %s", i, got_s(), want_s());
      end
      tick();
    end
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = $urandom;
    model_reset();
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the execute core. Reads 32-bit instruction words from the synchronous program RAM (one-cycle read latency) and buffers them in a 2-entry prefetch queue. Presents them to execute with a valid/ready handshake. Accepts a redirect (jump, GOSUB, RET, restart) that flushes queued and in-flight words and restarts fetch at a new PC.

## Interface
- START_PC, default 0: fetch PC loaded on reset.
- ADDR_WIDTH, default 11: program RAM word-address width (2048 words).
- CLK  in  1  system clock, 16 MHz, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- MEM_ADDR  out  ADDR_WIDTH  program RAM read address; equals fetch_pc[ADDR_WIDTH-1:0].
- MEM_REN  out  1  read request this cycle.
- MEM_RDATA  in  32  read data, valid the cycle after MEM_REN.
- INSTR  out  32  head-of-queue instruction word.
- INSTR_PC  out  32  PC of INSTR (execute uses INSTR_PC+1 for fall-through and GOSUB).
- INSTR_VALID  out  1  INSTR/INSTR_PC valid.
- INSTR_READY  in  1  execute consumes head this cycle when INSTR_VALID=1.
- REDIRECT  in  1  single-cycle pulse: discard everything and fetch from REDIRECT_PC.
- REDIRECT_PC  in  32  new fetch PC.

## Operation
- State: fetch_pc[31:0], inflight (1 bit), inflight_pc[31:0], 2-entry FIFO of {word, pc}, count[1:0].
- pop = INSTR_VALID & INSTR_READY; INSTR/INSTR_PC/INSTR_VALID come from the FIFO head, and INSTR_VALID = (count != 0).
- MEM_REN = !REDIRECT & ((count + inflight) < 2 | pop). The combinational path from INSTR_READY is required to sustain one instruction per cycle.
- On issue:
  - fetch_pc <= fetch_pc + 1, with 32-bit wrap.
  - inflight <= 1 and inflight_pc <= fetch_pc.
  - If there is no issue, inflight <= 0.
- Response capture: when inflight=1 and no REDIRECT this cycle, push {MEM_RDATA, inflight_pc} into the FIFO.
- FIFO update:
  - A push and a pop in the same cycle leave count unchanged, with data shifting correctly.
  - The credit rule guarantees no push into a full queue. If a push into a full queue ever occurs, it is a bench assertion failure.
- Redirect (highest priority) takes effect at the edge ending the REDIRECT cycle:
  - count <= 0, inflight <= 0, fetch_pc <= REDIRECT_PC.
  - Any pop in that cycle is still honoured by execute, but the queue is cleared regardless.
  - The response for a read issued in the REDIRECT cycle is suppressed, because MEM_REN=0 in that cycle.
- Address wrap: MEM_ADDR is fetch_pc truncated to ADDR_WIDTH bits, so PC 2047 is followed by address 0. INSTR_PC keeps the full 32-bit value, e.g. 2048.
- The block never modifies or decodes instruction words.

## Timing
- Reset values (RST_N low, asynchronous):
  - fetch_pc=START_PC, count=0, inflight=0.
  - INSTR_VALID=0, INSTR=0, INSTR_PC=0.
  - MEM_REN becomes 1 combinationally as soon as reset is released (credit available); MEM_ADDR=START_PC.
- Startup: first edge after RST_N rises issues read of START_PC (cycle 0). Data arrives in cycle 1 and is pushed at the end of cycle 1. INSTR_VALID=1 in cycle 2.
- Fetch latency: 2 cycles from MEM_REN to INSTR_VALID.
- Steady state with INSTR_READY=1: one instruction per cycle, MEM_REN held high, consecutive PCs.
- Stall (INSTR_READY=0): queue fills to 2, then MEM_REN=0. The head is held stable and unchanged until popped.
- Redirect in cycle R: MEM_REN=0 in R. Read of REDIRECT_PC issues in R+1, INSTR_VALID=0 in R+1 and R+2, and the new instruction is valid in R+3.
- Back-to-back REDIRECT pulses: the last one wins. Each pulse restarts the 3-cycle redirect latency.
- Reset asserted mid-operation: all state clears immediately, and an outstanding RAM response is ignored.

## Test plan
- Reset, RAM[0..3]=20000001,10000010,20000000,30000000, INSTR_READY=1 -> INSTR_VALID first high 2 cycles after reset release; words delivered in order on consecutive cycles with INSTR_PC 0,1,2,3.
- INSTR_READY=0 for 10 cycles after first valid -> exactly 2 reads issued then MEM_REN=0; INSTR stays 20000001/PC 0; on release PCs 0,1,2 delivered with no gap or duplicate.
- REDIRECT=1, REDIRECT_PC=0x40 while 2 queued and 1 in flight -> no word from PCs already fetched ever appears; next valid is RAM[0x40] with INSTR_PC=0x40, 3 cycles after the pulse.
- REDIRECT coincident with pop (INSTR_READY=1, INSTR_VALID=1) -> queue empty next cycle, fetch resumes at REDIRECT_PC, count never underflows.
- REDIRECT_PC=2046, streaming -> MEM_ADDR 2046,2047,0,1; INSTR_PC 2046,2047,2048,2049.
- RST_N pulsed low for 1 cycle mid-stream with a read in flight -> INSTR_VALID drops immediately; the following word is RAM[START_PC] with INSTR_PC=START_PC.
